// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT output-reorder stage:
//   - default values for the reorder stage parameters
//   - bitrev    : reverse the low log2n bits of an index (log2n <= 10)
//   - sat_narrow: arithmetic right shift followed by wrap or signed clamp
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int LOG2N_DEF = 5;
    localparam int IW_DEF    = 24;
    localparam int DW_DEF    = 16;
    localparam int SHIFT_DEF = 8;
    localparam int SAT_DEF   = 0;
    localparam int MAX_LOG2N = 10;

    // Reverse bits [log2n-1:0] of c; bits above log2n are returned as zero.
    function automatic logic [9:0] bitrev(input logic [9:0] c, input int log2n);
        logic [9:0] r;
        logic [3:0] src;
        r = 10'd0;
        for (int b = 0; b < MAX_LOG2N; b++) begin
            if (b < log2n) begin
                src  = 4'(log2n - 1 - b);
                r[b] = c[src];
            end else begin
                r[b] = 1'b0;
            end
        end
        return r;
    endfunction

    // v is the sign-extended input sample. The shift floors toward -inf.
    // With sat=0 the caller keeps the low dw bits (wrap); with sat=1 the
    // result is clamped to the signed dw-bit range first. dw must be < 64.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                      input int               shift,
                                                      input int               dw,
                                                      input logic             sat);
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        sh = v >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sat && (sh > hi)) begin
            r = hi;
        end else if (sat && (sh < lo)) begin
            r = lo;
        end else begin
            r = sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// -----------------------------------------------------------------------------
// fft_pp_bank
// Ping-pong sample store: two banks of 2^LOG2N words of W bits. One write
// port and one registered read port, each selecting its bank with a bank bit.
// The read register is the output data register of the reorder stage, so it
// is reset and only updates when rd_en_i is high (holds under back-pressure).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wr_en_i/wr_bank_i/wr_addr_i/wr_data_i   write port
//   rd_en_i/rd_bank_i/rd_addr_i             read request
//   rd_data_o                  registered read data
// -----------------------------------------------------------------------------
module fft_pp_bank #(
    parameter int LOG2N = 5,
    parameter int W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             wr_bank_i,
    input  logic [LOG2N-1:0] wr_addr_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_bank_i,
    input  logic [LOG2N-1:0] rd_addr_i,
    output logic [W-1:0]     rd_data_o
);

    localparam int DEPTH = 2 << LOG2N;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    // Sample array write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
    end

    // Registered read port, cleared by reset, held when not enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= {W{1'b0}};
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
// Output reorder stage after the last SDF butterfly. Bit-reversed-order
// samples are narrowed (shift, wrap or saturate) and written into a ping-pong
// buffer at bitrev(count); the read side walks the full bank in natural order
// and presents one bin per transfer through a one-deep registered output.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_sof marks sample 0 of a frame
//   in_r, in_i            IW-bit signed input sample, bit-reversed order
//   out_valid/out_ready   output handshake
//   out_r, out_i          DW-bit narrowed bin, natural order
//   out_index, out_last   bin index k and k==N-1 marker
//   sof_err               sticky: in_sof accepted mid-frame
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int IW    = IW_DEF,
    parameter int DW    = DW_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int SAT   = SAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [IW-1:0]    in_r,
    input  logic [IW-1:0]    in_i,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_r,
    output logic [DW-1:0]    out_i,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last,
    output logic             sof_err
);

    localparam logic [LOG2N-1:0] LAST_ADDR = {LOG2N{1'b1}};

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       full_q, full_d;
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [LOG2N-1:0] out_index_q, out_index_d;
    logic             sof_err_q, sof_err_d;

    logic               accept_s;
    logic [LOG2N-1:0]   c_eff_s;
    logic               wr_last_s;
    logic               load_s;
    logic               rd_last_s;
    logic [LOG2N-1:0]   wr_addr_s;
    logic signed [63:0] in_r_ext_s;
    logic signed [63:0] in_i_ext_s;
    logic [DW-1:0]      narrow_r_s;
    logic [DW-1:0]      narrow_i_s;
    logic [2*DW-1:0]    rd_data_s;

    assign in_r_ext_s = {{(64-IW){in_r[IW-1]}}, in_r};
    assign in_i_ext_s = {{(64-IW){in_i[IW-1]}}, in_i};

    // The writer only ever waits on its own bank being drained.
    assign in_ready = ~full_q[wb_q];
    assign accept_s = in_valid & in_ready;
    // A sof sample always restarts the frame at count 0 in the current bank.
    assign c_eff_s   = in_sof ? {LOG2N{1'b0}} : wr_cnt_q;
    assign wr_last_s = accept_s & (c_eff_s == LAST_ADDR);
    assign load_s    = full_q[rb_q] & (~out_valid_q | out_ready);
    assign rd_last_s = load_s & (rd_cnt_q == LAST_ADDR);

    // Write address and narrowed data for the incoming sample.
    always_comb begin
        wr_addr_s  = LOG2N'(bitrev(10'(c_eff_s), LOG2N));
        narrow_r_s = DW'(sat_narrow(in_r_ext_s, SHIFT, DW, SAT != 0));
        narrow_i_s = DW'(sat_narrow(in_i_ext_s, SHIFT, DW, SAT != 0));
    end

    // Next-state for counters, bank pointers, full flags and output control.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        full_d      = full_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_index_d = out_index_q;
        sof_err_d   = sof_err_q;

        if (accept_s) begin
            if (wr_last_s) begin
                wr_cnt_d     = {LOG2N{1'b0}};
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wr_cnt_d = c_eff_s + {{(LOG2N-1){1'b0}}, 1'b1};
            end
            if (in_sof && (wr_cnt_q != {LOG2N{1'b0}})) begin
                sof_err_d = 1'b1;
            end else begin
                sof_err_d = sof_err_q;
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end

        // The read bank is always full here, so it never collides with the
        // bank the writer just marked full in the same cycle.
        if (load_s) begin
            out_valid_d = 1'b1;
            out_index_d = rd_cnt_q;
            out_last_d  = (rd_cnt_q == LAST_ADDR);
            rd_cnt_d    = rd_cnt_q + {{(LOG2N-1){1'b0}}, 1'b1};
            if (rd_last_s) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end else begin
                rb_d = rb_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q    <= {LOG2N{1'b0}};
            rd_cnt_q    <= {LOG2N{1'b0}};
            full_q      <= 2'b00;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= {LOG2N{1'b0}};
            sof_err_q   <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
            sof_err_q   <= sof_err_d;
        end
    end

    fft_pp_bank #(
        .LOG2N (LOG2N),
        .W     (2*DW)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept_s),
        .wr_bank_i (wb_q),
        .wr_addr_i (wr_addr_s),
        .wr_data_i ({narrow_r_s, narrow_i_s}),
        .rd_en_i   (load_s),
        .rd_bank_i (rb_q),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (rd_data_s)
    );

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign out_r     = rd_data_s[2*DW-1:DW];
    assign out_i     = rd_data_s[DW-1:0];
    assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
// Directed bench for the reorder stage. Three instances share the stimulus:
// u_dut (SHIFT=8, wrap), u_wrap (SHIFT=0, wrap), u_sat (SHIFT=0, saturate).
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

    localparam int LOG2N = 5;
    localparam int IW    = 24;
    localparam int DW    = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_sof;
    logic [IW-1:0]    in_r;
    logic [IW-1:0]    in_i;
    logic             out_ready;

    logic             m_in_ready, m_out_valid, m_out_last, m_sof_err;
    logic [DW-1:0]    m_out_r, m_out_i;
    logic [LOG2N-1:0] m_out_index;
    logic             w_in_ready, w_out_valid, w_out_last, w_sof_err;
    logic [DW-1:0]    w_out_r, w_out_i;
    logic [LOG2N-1:0] w_out_index;
    logic             s_in_ready, s_out_valid, s_out_last, s_sof_err;
    logic [DW-1:0]    s_out_r, s_out_i;
    logic [LOG2N-1:0] s_out_index;

    fft_bitrev_reorder #(.LOG2N(LOG2N), .IW(IW), .DW(DW), .SHIFT(8), .SAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_r(in_r), .in_i(in_i), .in_ready(m_in_ready), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_r(m_out_r), .out_i(m_out_i),
        .out_index(m_out_index), .out_last(m_out_last), .sof_err(m_sof_err));

    fft_bitrev_reorder #(.LOG2N(LOG2N), .IW(IW), .DW(DW), .SHIFT(0), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_r(in_r), .in_i(in_i), .in_ready(w_in_ready), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_r(w_out_r), .out_i(w_out_i),
        .out_index(w_out_index), .out_last(w_out_last), .sof_err(w_sof_err));

    fft_bitrev_reorder #(.LOG2N(LOG2N), .IW(IW), .DW(DW), .SHIFT(0), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_r(in_r), .in_i(in_i), .in_ready(s_in_ready), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_r(s_out_r), .out_i(s_out_i),
        .out_index(s_out_index), .out_last(s_out_last), .sof_err(s_sof_err));

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] b_idx[$];
    logic [15:0] b_r[$];
    logic [15:0] b_i[$];
    logic [15:0] b_last[$];
    int          b_cyc[$];
    logic [15:0] bw_r[$];
    logic [15:0] bw_i[$];
    logic [15:0] bs_r[$];
    logic [15:0] bs_i[$];

    int   first_valid_cyc, last_acc_cyc, acc_cnt, stall_cnt;
    bit   seen_valid, seen31, drv_done;
    logic rdy_at31, rdy_pre31, prev_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int brev5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) if (k & (1 << b)) r |= (1 << (4 - b));
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        b_idx.delete(); b_r.delete(); b_i.delete(); b_last.delete(); b_cyc.delete();
        bw_r.delete(); bw_i.delete(); bs_r.delete(); bs_i.delete();
        seen_valid = 1'b0; seen31 = 1'b0; acc_cnt = 0; stall_cnt = 0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_out_valid && out_ready) begin
                    b_idx.push_back(16'(m_out_index)); b_r.push_back(m_out_r);
                    b_i.push_back(m_out_i); b_last.push_back(16'(m_out_last));
                    b_cyc.push_back(cyc);
                    bw_r.push_back(w_out_r); bw_i.push_back(w_out_i);
                    bs_r.push_back(s_out_r); bs_i.push_back(s_out_i);
                end
                if (m_out_valid && !seen_valid) begin
                    seen_valid = 1'b1; first_valid_cyc = cyc;
                end
                if (m_out_valid && (m_out_index == 5'd31) && !seen31) begin
                    seen31 = 1'b1; rdy_at31 = m_in_ready; rdy_pre31 = prev_rdy;
                end
                if (in_valid && m_in_ready) begin
                    acc_cnt++; last_acc_cyc = cyc;
                end
                if (in_valid && !m_in_ready) stall_cnt++;
            end
            prev_rdy = m_in_ready;
        end
    endtask

    task automatic put(input logic [IW-1:0] r, input logic [IW-1:0] i, input logic sof);
        int guard = 0;
        in_valid = 1'b1; in_r = r; in_i = i; in_sof = sof;
        @(negedge clk);
        while (!m_in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!m_in_ready) check("in_ready_timeout", 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_frame(input int f, input bit sof);
        for (int c = 0; c < 32; c++) begin
            int v = f * 32 + c;
            put(24'(v << 8), 24'(-(v << 8)), sof && (c == 0));
        end
    endtask

    task automatic wait_bins(input string tag, input int n, input int budget);
        int g = 0;
        while (b_idx.size() < n && g < budget) begin
            tick(1);
            g++;
        end
        check(tag, 32'(b_idx.size()), 32'(n));
    endtask

    task automatic check_frames(input string tag, input int nf);
        logic [15:0] er, ei;
        for (int j = 0; j < nf * 32 && j < b_idx.size(); j++) begin
            int f = j / 32;
            int k = j % 32;
            er = 16'(f * 32 + brev5(k));
            ei = 16'(-(f * 32 + brev5(k)));
            check($sformatf("%s_idx[%0d]", tag, j), 32'(b_idx[j]), 32'(k));
            check($sformatf("%s_r[%0d]", tag, j), 32'(b_r[j]), 32'(er));
            check($sformatf("%s_i[%0d]", tag, j), 32'(b_i[j]), 32'(ei));
            check($sformatf("%s_last[%0d]", tag, j), 32'(b_last[j]), (k == 31) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        clear_mon();
    endtask

    initial begin
        int gaps;
        int g;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_r = 24'h0; in_i = 24'h0; out_ready = 1'b1;
        clear_mon();
        prev_rdy = 1'b0; rdy_at31 = 1'b0; rdy_pre31 = 1'b0;
        first_valid_cyc = 0; last_acc_cyc = 0; drv_done = 1'b0;
        fork monitor(); join_none
        tick(2);

        // Reset state
        check("rst_in_ready", 32'(m_in_ready), 32'd1);
        check("rst_out_valid", 32'(m_out_valid), 32'd0);
        check("rst_out_r", 32'(m_out_r), 32'd0);
        check("rst_out_index", 32'(m_out_index), 32'd0);
        check("rst_sof_err", 32'(m_sof_err), 32'd0);
        rst_n = 1'b1;
        clear_mon();

        // Test 1: single frame, natural-order output and latency
        send_frame(0, 1'b1);
        wait_bins("t1_count", 32, 100);
        check("t1_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd2);
        if (b_r.size() >= 32) begin
            check("t1_k1_r", 32'(b_r[1]), 32'd16);
            check("t1_k31_r", 32'(b_r[31]), 32'd31);
            check("t1_k1_i", 32'(b_i[1]), 32'h0000_FFF0);
        end
        check_frames("t1", 1);
        tick(5);
        check("t1_idle_valid", 32'(m_out_valid), 32'd0);

        // Test 2: three back-to-back frames, continuous streaming
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(f, 1'b1);
        wait_bins("t2_count", 96, 200);
        check("t2_no_stall", 32'(stall_cnt), 32'd0);
        gaps = 0;
        for (int j = 1; j < b_cyc.size(); j++) if (b_cyc[j] - b_cyc[j-1] != 1) gaps++;
        check("t2_gaps", 32'(gaps), 32'd0);
        check_frames("t2", 3);

        // Test 3: downstream stalled while three frames are offered
        do_reset();
        out_ready = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(f, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        tick(120);
        check("t3_accepted", 32'(acc_cnt), 32'd64);
        check("t3_in_ready_low", 32'(m_in_ready), 32'd0);
        check("t3_held_valid", 32'(m_out_valid), 32'd1);
        check("t3_held_index", 32'(m_out_index), 32'd0);
        out_ready = 1'b1;
        wait_bins("t3_count", 96, 400);
        g = 0;
        while (!drv_done && g < 400) begin tick(1); g++; end
        check("t3_drv_done", 32'(drv_done), 32'd1);
        check("t3_seen31", 32'(seen31), 32'd1);
        check("t3_rdy_before31", 32'(rdy_pre31), 32'd0);
        check("t3_rdy_at31", 32'(rdy_at31), 32'd1);
        check_frames("t3", 3);

        // Test 4: wrap versus saturate narrowing (SHIFT=0 instances)
        do_reset();
        put(24'h7FFFFF, 24'h800000, 1'b1);
        put(24'h012345, 24'hFEDCBA, 1'b0);
        for (int c = 2; c < 32; c++) put(24'h0, 24'h0, 1'b0);
        wait_bins("t4_count", 32, 100);
        if (b_idx.size() >= 32) begin
            check("t4_wrap_r0", 32'(bw_r[0]), 32'h0000_FFFF);
            check("t4_wrap_i0", 32'(bw_i[0]), 32'h0000_0000);
            check("t4_sat_r0", 32'(bs_r[0]), 32'h0000_7FFF);
            check("t4_sat_i0", 32'(bs_i[0]), 32'h0000_8000);
            check("t4_wrap_r16", 32'(bw_r[16]), 32'h0000_2345);
            check("t4_wrap_i16", 32'(bw_i[16]), 32'h0000_DCBA);
            check("t4_sat_r16", 32'(bs_r[16]), 32'h0000_7FFF);
            check("t4_sat_i16", 32'(bs_i[16]), 32'h0000_8000);
            check("t4_shift8_r0", 32'(b_r[0]), 32'h0000_7FFF);
            check("t4_shift8_i0", 32'(b_i[0]), 32'h0000_8000);
            check("t4_shift8_r16", 32'(b_r[16]), 32'h0000_0123);
            check("t4_shift8_i16", 32'(b_i[16]), 32'h0000_FEDC);
            check("t4_wrap_r5", 32'(bw_r[5]), 32'h0000_0000);
        end

        // Test 5: in_sof at c=10 restarts the frame
        do_reset();
        for (int c = 0; c < 10; c++) put(24'h0ABC00, 24'h0ABC00, c == 0);
        check("t5_sof_err_before", 32'(m_sof_err), 32'd0);
        send_frame(0, 1'b1);
        check("t5_sof_err", 32'(m_sof_err), 32'd1);
        wait_bins("t5_count", 32, 100);
        tick(20);
        check("t5_no_extra", 32'(b_idx.size()), 32'd32);
        check_frames("t5", 1);

        // Test 6: reset mid-output with one bank full
        clear_mon();
        out_ready = 1'b0;
        send_frame(1, 1'b1);
        tick(3);
        check("t6_pre_valid", 32'(m_out_valid), 32'd1);
        check("t6_pre_sof_err", 32'(m_sof_err), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("t6_out_valid", 32'(m_out_valid), 32'd0);
        check("t6_out_r", 32'(m_out_r), 32'd0);
        check("t6_out_i", 32'(m_out_i), 32'd0);
        check("t6_out_index", 32'(m_out_index), 32'd0);
        check("t6_out_last", 32'(m_out_last), 32'd0);
        check("t6_sof_err", 32'(m_sof_err), 32'd0);
        check("t6_in_ready", 32'(m_in_ready), 32'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(50);
        check("t6_no_stale_bins", 32'(b_idx.size()), 32'd0);
        check("t6_idle_valid", 32'(m_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
